fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage sequencer for the 5-stage RISC-V core: owns the 8-bit program counter and decides each cycle whether it advances, holds or is redirected. It arbitrates branch/jump redirects from EX, load-use stalls from the hazard unit and instruction-memory wait states, then drives the instruction-memory request and the IF/ID valid and flush controls.

## Interface
- PC_W, 8, program-counter and instruction-address width (bits)
- RESET_PC, 8'h00, PC value loaded by reset
- TRAP_PC, 8'hF0, PC loaded on a misaligned redirect (only with FETCH_MISALIGN_TRAP_EN)
- PC_INC, 4, sequential increment (bytes per instruction)
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- stall_req  in  1  load-use stall from hazard unit; hold PC
- redirect_valid  in  1  taken branch / jump resolved in EX
- redirect_target  in  PC_W  redirect destination address
- imem_ready  in  1  instruction for imem_addr is available this cycle
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_W  fetch address (= current PC)
- pc_out  out  PC_W  PC of the instruction handed to IF/ID
- if_valid  out  1  IF/ID captures a valid instruction this cycle
- flush  out  1  kill IF/ID and ID/EX contents this cycle
- pc_stall  out  1  PC held this cycle (debug/hazard visibility)
- misalign_trap  out  1  one-cycle misaligned-redirect pulse (tied 0 without macro)

## Operation
- States: BOOT, FETCH, WAIT.
- BOOT: first cycle after reset release; imem_req=0, PC held at RESET_PC; next state FETCH unconditionally.
- FETCH/WAIT: imem_req=1, imem_addr=PC. Per-cycle priority: redirect > stall > memory wait > advance.
  - redirect_valid=1: PC <= redirect_target; flush=1; if_valid=0; next FETCH. Overrides stall_req and imem_ready; an outstanding fetch is abandoned.
  - else stall_req=1: PC held; pc_stall=1; if_valid=0; state unchanged.
  - else imem_ready=0: PC held; pc_stall=1; next WAIT.
  - else: if_valid=1; pc_out=PC; PC <= PC + PC_INC; next FETCH.
- Arithmetic: PC + PC_INC is modulo 2^PC_W; 8'hFC advances to 8'h00 with no flag.
- Without the macro, redirect_target[1:0] is cleared before loading (forced word alignment).
- Redirect during BOOT is ignored (EX holds no valid instruction).
- Reset values: PC=RESET_PC, state=BOOT, imem_req=0, imem_addr=RESET_PC, pc_out=RESET_PC, if_valid=0, flush=0, pc_stall=1, misalign_trap=0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), regardless of pending redirect or wait.

## Timing
- PC and state registered; imem_req, imem_addr, pc_out, if_valid, flush, pc_stall, misalign_trap combinational from state, PC and current inputs.
- Redirect latency: target appears on imem_addr the cycle after redirect_valid is sampled.
- Sequential fetch throughput: one instruction per cycle while imem_ready=1 and no stall.
- Stall and wait add exactly one held cycle per cycle asserted; no lost or duplicated fetch.
- First imem_req is two cycles after reset deassertion edge (BOOT, then FETCH).

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_target[1:0]!=0 loads TRAP_PC instead, asserts flush and misalign_trap for that cycle.
- Not defined: low bits silently cleared; misalign_trap tied 0; TRAP_PC unused.

## Structure
- Package fetch_pkg: state enum (BOOT, FETCH, WAIT), PC_W, RESET_PC, TRAP_PC, PC_INC defaults.
- One sub-module, pc_next_sel: combinational priority select of next PC (redirect/trap, hold, increment) and alignment handling; fetch_ctrl keeps the state register, PC register and output decode.

## Test plan
- Reset release, imem_ready=1 constant -> imem_addr 00 (BOOT, req=0), then 00, 04, 08; if_valid high from second cycle after release.
- PC=0x10, stall_req high 2 cycles -> imem_addr stays 0x10 for 2 cycles, pc_stall=1, if_valid=0; then 0x14.
- PC=0x20, redirect_valid with target 0x40 while stall_req=1 and imem_ready=0 -> flush=1 same cycle, next imem_addr=0x40.
- PC=0xFC, imem_ready=1 -> next imem_addr=0x00, no flush.
- Redirect target 0x42: macro on -> next PC 0xF0, misalign_trap=1; macro off -> next PC 0x40, misalign_trap=0.
- reset driven low in WAIT at PC 0x30 -> outputs at reset values before next clk edge; BOOT sequence repeats on release.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state encoding for the fetch-stage sequencer.
//   PC_W      program-counter / instruction-address width
//   RESET_PC  PC loaded by reset
//   TRAP_PC   PC loaded on a misaligned redirect (FETCH_MISALIGN_TRAP_EN builds only)
//   PC_INC    sequential increment, bytes per instruction
package fetch_pkg;

  localparam int PC_W = 8;

  localparam logic [PC_W-1:0] RESET_PC = 8'h00;
  localparam logic [PC_W-1:0] TRAP_PC  = 8'hF0;
  localparam logic [PC_W-1:0] PC_INC   = 8'h04;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_if: handshake and bus signals between the fetch sequencer and its
// neighbours (EX redirect, hazard unit, instruction memory, IF/ID register).
//   master modport : fetch_ctrl side (drives imem request and IF/ID controls)
//   slave modport  : environment side (drives stall, redirect, imem_ready)
interface fetch_if import fetch_pkg::*; ();

  logic            stall_req;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic            imem_ready;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [PC_W-1:0] pc_out;
  logic            if_valid;
  logic            flush;
  logic            pc_stall;
  logic            misalign_trap;

  modport master (
    input  stall_req, redirect_valid, redirect_target, imem_ready,
    output imem_req, imem_addr, pc_out, if_valid, flush, pc_stall, misalign_trap
  );

  modport slave (
    output stall_req, redirect_valid, redirect_target, imem_ready,
    input  imem_req, imem_addr, pc_out, if_valid, flush, pc_stall, misalign_trap
  );

endinterface

// File: rtl/fetch_ctrl_pc_next_sel.sv
// pc_next_sel: combinational next-PC select for the fetch sequencer.
// Priority: redirect (or trap) > hold > sequential increment.
//   pc        in  current PC
//   target    in  redirect destination from EX
//   redirect  in  redirect accepted this cycle (already gated by state)
//   hold      in  PC must not advance (boot, stall or imem wait)
//   pc_next   out value for the PC register
//   misalign  out misaligned redirect trapped this cycle
// Build option FETCH_MISALIGN_TRAP_EN: misaligned targets load TRAP_PC and
// raise misalign; otherwise the low two target bits are cleared and misalign
// stays 0.
module pc_next_sel import fetch_pkg::*; (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target,
  input  logic            redirect,
  input  logic            hold,
  output logic [PC_W-1:0] pc_next,
  output logic            misalign
);

  localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

  always_comb begin
    pc_next  = pc;
    misalign = 1'b0;
    if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (target[1:0] != 2'b00) begin
        pc_next  = TRAP_PC;
        misalign = 1'b1;
      end else begin
        pc_next  = target;
      end
`else
      pc_next = target & ALIGN_MASK;
`endif
    end else if (!hold) begin
      // wraps modulo 2^PC_W with no carry out
      pc_next = pc + PC_INC;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Owns the program counter and each cycle
// redirects, holds or advances it, driving the imem request and IF/ID controls.
//   clk    in  single clock, all state changes on posedge
//   reset  in  asynchronous active-low reset
//   bus    fetch_if.master: stall_req, redirect_valid, redirect_target,
//          imem_ready in; imem_req, imem_addr, pc_out, if_valid, flush,
//          pc_stall, misalign_trap out (all outputs combinational)
// Build option FETCH_MISALIGN_TRAP_EN enables trapping misaligned redirects.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch issued, PC held at RESET_PC
// FETCH | fetch request issued at PC
// WAIT  | previous fetch saw imem_ready=0, request re-issued at same PC
module fetch_ctrl import fetch_pkg::*; (
  input logic    clk,
  input logic    reset,
  fetch_if.master bus
);

  localparam logic [1:0] S_BOOT  = ST_BOOT;
  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_WAIT  = ST_WAIT;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nxt;
  logic            active;
  logic            take_redirect;
  logic            hold;
  logic            misalign;

  // EX holds nothing valid during BOOT, so redirects are ignored there
  assign active        = (state != S_BOOT);
  assign take_redirect = active & bus.redirect_valid;
  assign hold          = ~active | bus.stall_req | ~bus.imem_ready;

  pc_next_sel u_pc_next_sel (
    .pc       (pc),
    .target   (bus.redirect_target),
    .redirect (take_redirect),
    .hold     (hold),
    .pc_next  (pc_nxt),
    .misalign (misalign)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH,
      S_WAIT: begin
        if (bus.redirect_valid)   state_nxt = S_FETCH;
        else if (bus.stall_req)   state_nxt = state;
        else if (!bus.imem_ready) state_nxt = S_WAIT;
        else                      state_nxt = S_FETCH;
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  assign bus.imem_req      = active;
  assign bus.imem_addr     = pc;
  assign bus.pc_out        = pc;
  assign bus.flush         = take_redirect;
  assign bus.if_valid      = active & ~bus.redirect_valid & ~bus.stall_req & bus.imem_ready;
  assign bus.pc_stall      = ~take_redirect & hold;
  assign bus.misalign_trap = misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  fetch_if bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},      {7'd0, bus.imem_req},      8'h00);
    chk({tag, "_addr"},     bus.imem_addr,             RESET_PC);
    chk({tag, "_pc_out"},   bus.pc_out,                RESET_PC);
    chk({tag, "_if_valid"}, {7'd0, bus.if_valid},      8'h00);
    chk({tag, "_flush"},    {7'd0, bus.flush},         8'h00);
    chk({tag, "_pc_stall"}, {7'd0, bus.pc_stall},      8'h01);
    chk({tag, "_misalign"}, {7'd0, bus.misalign_trap}, 8'h00);
  endtask

  initial begin
    logic [7:0] exp_mis_pc;
    logic [7:0] exp_mis_flag;
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_mis_pc   = 8'hF0;
    exp_mis_flag = 8'h01;
`else
    exp_mis_pc   = 8'h40;
    exp_mis_flag = 8'h00;
`endif

    reset = 1'b0;
    bus.stall_req = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 8'h00;
    bus.imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_reset_vals("rst");

    // reset release: BOOT, then sequential fetch 00,04,08,0C,10
    @(negedge clk); reset = 1'b1;
    #1 chk("boot_req", {7'd0, bus.imem_req}, 8'h00);
    chk("boot_addr", bus.imem_addr, 8'h00);
    chk("boot_valid", {7'd0, bus.if_valid}, 8'h00);
    @(negedge clk);
    #1 chk("f0_req", {7'd0, bus.imem_req}, 8'h01);
    chk("f0_addr", bus.imem_addr, 8'h00);
    chk("f0_valid", {7'd0, bus.if_valid}, 8'h01);
    chk("f0_pc_out", bus.pc_out, 8'h00);
    @(negedge clk); #1 chk("f1_addr", bus.imem_addr, 8'h04);
    chk("f1_valid", {7'd0, bus.if_valid}, 8'h01);
    @(negedge clk); #1 chk("f2_addr", bus.imem_addr, 8'h08);
    @(negedge clk); #1 chk("f3_addr", bus.imem_addr, 8'h0C);
    @(negedge clk); #1 chk("f4_addr", bus.imem_addr, 8'h10);

    // stall two cycles at 0x10
    bus.stall_req = 1'b1;
    #1 chk("st0_addr", bus.imem_addr, 8'h10);
    chk("st0_pc_stall", {7'd0, bus.pc_stall}, 8'h01);
    chk("st0_valid", {7'd0, bus.if_valid}, 8'h00);
    @(negedge clk);
    #1 chk("st1_addr", bus.imem_addr, 8'h10);
    chk("st1_pc_stall", {7'd0, bus.pc_stall}, 8'h01);
    chk("st1_valid", {7'd0, bus.if_valid}, 8'h00);
    @(negedge clk); bus.stall_req = 1'b0;
    #1 chk("st2_addr", bus.imem_addr, 8'h10);
    chk("st2_valid", {7'd0, bus.if_valid}, 8'h01);
    chk("st2_pc_stall", {7'd0, bus.pc_stall}, 8'h00);
    @(negedge clk); #1 chk("st3_addr", bus.imem_addr, 8'h14);

    // plain redirect to 0x20
    bus.redirect_valid = 1'b1; bus.redirect_target = 8'h20;
    #1 chk("rd0_flush", {7'd0, bus.flush}, 8'h01);
    chk("rd0_valid", {7'd0, bus.if_valid}, 8'h00);
    @(negedge clk); bus.redirect_valid = 1'b0;
    #1 chk("rd0_addr", bus.imem_addr, 8'h20);
    chk("rd0_flush_off", {7'd0, bus.flush}, 8'h00);

    // redirect to 0x40 overrides stall and imem wait
    bus.redirect_valid = 1'b1; bus.redirect_target = 8'h40;
    bus.stall_req = 1'b1; bus.imem_ready = 1'b0;
    #1 chk("rd1_flush", {7'd0, bus.flush}, 8'h01);
    chk("rd1_valid", {7'd0, bus.if_valid}, 8'h00);
    chk("rd1_pc_stall", {7'd0, bus.pc_stall}, 8'h00);
    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.stall_req = 1'b0;
    #1 chk("rd1_addr", bus.imem_addr, 8'h40);
    chk("w0_pc_stall", {7'd0, bus.pc_stall}, 8'h01);
    chk("w0_valid", {7'd0, bus.if_valid}, 8'h00);
    @(negedge clk); bus.imem_ready = 1'b1;
    #1 chk("w1_addr", bus.imem_addr, 8'h40);
    chk("w1_valid", {7'd0, bus.if_valid}, 8'h01);
    chk("w1_pc_out", bus.pc_out, 8'h40);
    @(negedge clk); #1 chk("w2_addr", bus.imem_addr, 8'h44);

    // wrap 0xFC -> 0x00
    bus.redirect_valid = 1'b1; bus.redirect_target = 8'hFC;
    @(negedge clk); bus.redirect_valid = 1'b0;
    #1 chk("wr0_addr", bus.imem_addr, 8'hFC);
    chk("wr0_valid", {7'd0, bus.if_valid}, 8'h01);
    @(negedge clk);
    #1 chk("wr1_addr", bus.imem_addr, 8'h00);
    chk("wr1_flush", {7'd0, bus.flush}, 8'h00);

    // misaligned redirect target 0x42
    bus.redirect_valid = 1'b1; bus.redirect_target = 8'h42;
    #1 chk("mis_flag", {7'd0, bus.misalign_trap}, exp_mis_flag);
    chk("mis_flush", {7'd0, bus.flush}, 8'h01);
    @(negedge clk); bus.redirect_valid = 1'b0;
    #1 chk("mis_addr", bus.imem_addr, exp_mis_pc);
    chk("mis_flag_off", {7'd0, bus.misalign_trap}, 8'h00);

    // enter WAIT at 0x30, then async reset with a redirect pending
    bus.redirect_valid = 1'b1; bus.redirect_target = 8'h30;
    @(negedge clk); bus.redirect_valid = 1'b0; bus.imem_ready = 1'b0;
    #1 chk("ar0_addr", bus.imem_addr, 8'h30);
    chk("ar0_pc_stall", {7'd0, bus.pc_stall}, 8'h01);
    @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_target = 8'h50;
    #1 chk("ar1_flush", {7'd0, bus.flush}, 8'h01);
    #1 reset = 1'b0;
    #1 chk_reset_vals("arst");

    // release; redirect during BOOT must be ignored
    @(negedge clk); reset = 1'b1; bus.imem_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_target = 8'h80;
    #1 chk("b2_req", {7'd0, bus.imem_req}, 8'h00);
    chk("b2_addr", bus.imem_addr, 8'h00);
    chk("b2_flush", {7'd0, bus.flush}, 8'h00);
    @(negedge clk); bus.redirect_valid = 1'b0;
    #1 chk("b2f0_req", {7'd0, bus.imem_req}, 8'h01);
    chk("b2f0_addr", bus.imem_addr, 8'h00);
    chk("b2f0_valid", {7'd0, bus.if_valid}, 8'h01);
    @(negedge clk); #1 chk("b2f1_addr", bus.imem_addr, 8'h04);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
